iob_ram_wait_slave: RTL and testbench
=====================================

// Module: iob_ram_wait_slave
// PURPOSE
//  IOb slave RAM that consumes the IOb master port of the Wishbone-to-IOb bridge.
//  Accepts one request per valid_i pulse, inserts WAIT_CYCLES programmable wait states,
//  then returns a single-cycle ready_o with registered rdata_o.
//  Used as the DMA buffer memory behind the MAC's Wishbone master and as a latency model for bridge verification.
// PARAMETERS
//  ADDR_W       32  IOb byte-address width
//  DATA_W       32  data width; multiple of 8; DATA_W/8 byte strobes
//  MEM_ADDR_W   10  word-address width of the array (2**MEM_ADDR_W words)
//  WAIT_CYCLES  2   wait states before response; 0 allowed
// PORTS
//  clk_i      in   1           clock; all logic on rising edge
//  rst_i      in   1           synchronous, active-high reset
//  valid_i    in   1           request strobe; one-cycle pulse per request
//  address_i  in   ADDR_W      byte address; sampled only when valid_i=1 is accepted
//  wdata_i    in   DATA_W      write data; sampled with address_i
//  wstrb_i    in   DATA_W/8    byte enables; all-zero = read
//  rdata_o    out  DATA_W      read data; valid while ready_o=1, held until next response
//  ready_o    out  1           one-cycle response strobe
//  busy_o     out  1           request in flight (state != IDLE)
//  overrun_o  out  1           sticky: valid_i seen while busy
// BEHAVIOUR
//  Reset: rdata_o=0, ready_o=0, busy_o=0, overrun_o=0, state=IDLE, wait counter=0.
//   Array contents are not reset.
//  Word index = address_i[LSB+MEM_ADDR_W-1:LSB], where LSB = clog2(DATA_W/8).
//   Out of range: any address_i bit above LSB+MEM_ADDR_W-1 set.
//  FSM states:
//   IDLE:   on valid_i, latch address/wdata/wstrb and the out-of-range flag; cnt <= WAIT_CYCLES.
//           Go to WAIT if WAIT_CYCLES>0, else to ACCESS.
//   WAIT:   cnt decrements each cycle; at cnt==1 go to ACCESS.
//   ACCESS: one cycle. Commit write (per-byte wstrb) or read the array.
//           Register ready_o=1 and rdata_o; go to IDLE.
//  Latency: valid_i at cycle t -> ready_o=1 exactly at cycle t+1+WAIT_CYCLES, for one cycle.
//  Write commit: the array is updated on the same edge that raises ready_o. rdata_o is unchanged on writes.
//  Read-after-write: a read issued after the write's ready_o returns the new data.
//  Out-of-range access:
//   - write: dropped, no array change.
//   - read: rdata_o=0.
//   - ready_o timing unchanged.
//  Back-to-back: valid_i in the same cycle as ready_o=1 is accepted (FSM already IDLE).
//  valid_i while busy_o=1: ignored, overrun_o <= 1; the current request completes normally.
//  overrun_o clears only on rst_i.
//  Held inputs: address_i/wdata_i/wstrb_i are don't-care outside the accepting cycle.
//  Reset mid-operation: the request is abandoned. No ready_o, no array write, rdata_o=0.
//  Counter width: clog2(WAIT_CYCLES+1), minimum 1 bit.
// STRUCTURE
//  iob_ram_wait_defs.vh: FSM state encodings (IDLE=2'd0, WAIT=2'd1, ACCESS=2'd2), LSB localparam helper.
//  Sub-module iob_ram_sp_be: single-port byte-enable RAM with registered read (DATA_W, MEM_ADDR_W).
//  The top holds the FSM, request latches, counter, range check and flags.
// TESTING
//  1. Reset pulse -> rdata_o=0, ready_o=0, busy_o=0, overrun_o=0; valid_i during reset produces no ready_o.
//  2. WAIT_CYCLES=2:
//     - write 0x10, 0xDEADBEEF, wstrb=0xF at t -> ready_o only at t+3, busy_o high t+1..t+2.
//     - then read 0x10 at t' -> rdata_o=0xDEADBEEF with ready_o at t'+3.
//  3. Byte strobes: write 0x000000A5, wstrb=0x1 to 0x10 -> read returns 0xDEADBEA5.
//     Write wstrb=0xC, 0x12340000 -> read returns 0x1234BEA5.
//  4. Overrun: valid_i at t and again at t+1 -> single ready_o at t+3, second request dropped;
//     overrun_o=1 from t+2 until reset.
//  5. Out of range (MEM_ADDR_W=10, address 0x1000):
//     - write 0xFFFFFFFF -> ready_o at t+3; read of 0x0 is unchanged.
//     - read of 0x1000 -> rdata_o=0.
//  6. WAIT_CYCLES=0:
//     - back-to-back reads -> ready_o at t+1 each; valid_i coincident with ready_o is accepted.
//     - reset asserted at t+1 of a WAIT_CYCLES=2 write -> no ready_o, array unchanged.

Source files
------------

// File: rtl/iob_ram_wait_slave_pkg.sv
// Shared types and helpers for the IOb wait-state RAM slave.
//   state_e   : FSM state encoding (IDLE=0, WAIT=1, ACCESS=2)
//   lsb_of    : byte-offset width of a data word
//   cnt_width : wait-counter width, never below 1 bit
package iob_ram_wait_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  function automatic int unsigned lsb_of(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned wait_cycles);
    return (wait_cycles == 0) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/iob_ram_wait_slave_if.sv
// IOb request/response bundle between a master and the wait-state RAM slave.
//   valid_i/address_i/wdata_i/wstrb_i : request (master -> slave)
//   rdata_o/ready_o                   : response (slave -> master)
//   busy_o/overrun_o                  : slave status
interface iob_ram_wait_slave_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  valid_i;
  logic [ADDR_W-1:0]     address_i;
  logic [DATA_W-1:0]     wdata_i;
  logic [DATA_W/8-1:0]   wstrb_i;
  logic [DATA_W-1:0]     rdata_o;
  logic                  ready_o;
  logic                  busy_o;
  logic                  overrun_o;

  modport master (
    output valid_i, address_i, wdata_i, wstrb_i,
    input  rdata_o, ready_o, busy_o, overrun_o
  );

  modport slave (
    input  valid_i, address_i, wdata_i, wstrb_i,
    output rdata_o, ready_o, busy_o, overrun_o
  );
endinterface

// File: rtl/iob_ram_wait_slave_ram.sv
// Single-port byte-enable RAM with registered read.
//   clk_i, rst_i : clock, synchronous active-high reset (read register only)
//   en_i         : access strobe; we_i all-zero = read, else per-byte write
//   clr_i        : force the read register to zero
//   rdata_o      : read register, holds between reads
module iob_ram_sp_be #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_ADDR_W = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [DATA_W/8-1:0]   we_i,
  input  logic [MEM_ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic                  clr_i,
  output logic [DATA_W-1:0]     rdata_o
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned DEPTH  = 2 ** MEM_ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  // Array storage; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (we_i[b]) mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  // Read register only moves on a read or an explicit clear.
  always_comb begin
    rdata_d = rdata_q;
    if (clr_i)                     rdata_d = '0;
    else if (en_i && we_i == '0)   rdata_d = mem[addr_i];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/iob_ram_wait_slave.sv
// IOb slave RAM with programmable wait states ahead of each response.
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   bus   : IOb slave port (request in, rdata/ready/busy/overrun out)
// The array is touched on the edge that raises ready_o, so ready_o lands
// exactly 1+WAIT_CYCLES cycles after the accepting cycle.
module iob_ram_wait_slave
  import iob_ram_wait_slave_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_ADDR_W  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  iob_ram_wait_slave_if.slave  bus
);
  localparam int unsigned LSB    = lsb_of(DATA_W);
  localparam int unsigned CNT_W  = cnt_width(WAIT_CYCLES);
  localparam int unsigned STRB_W = DATA_W / 8;

  state_e                state_d, state_q;
  logic [CNT_W-1:0]      cnt_d, cnt_q;
  logic [MEM_ADDR_W-1:0] idx_d, idx_q;
  logic [DATA_W-1:0]     wdata_d, wdata_q;
  logic [STRB_W-1:0]     wstrb_d, wstrb_q;
  logic                  oor_d, oor_q;
  logic                  ready_d, ready_q;
  logic                  overrun_d, overrun_q;

  logic                  in_oor;
  logic                  fire;
  logic [MEM_ADDR_W-1:0] acc_idx;
  logic [DATA_W-1:0]     acc_wdata;
  logic [STRB_W-1:0]     acc_wstrb;
  logic                  acc_oor;
  logic                  ram_en, ram_clr;
  logic [DATA_W-1:0]     ram_rdata;

  // Any address bit above the word index marks the request out of range.
  assign in_oor = (bus.address_i >> (LSB + MEM_ADDR_W)) != '0;

  // Next state, request latches and access strobe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    oor_d     = oor_q;
    ready_d   = 1'b0;
    overrun_d = overrun_q;
    fire      = 1'b0;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    acc_wstrb = wstrb_q;
    acc_oor   = oor_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.valid_i) begin
          idx_d   = bus.address_i[LSB +: MEM_ADDR_W];
          wdata_d = bus.wdata_i;
          wstrb_d = bus.wstrb_i;
          oor_d   = in_oor;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            // Zero wait states: access straight from the live request.
            fire      = 1'b1;
            acc_idx   = bus.address_i[LSB +: MEM_ADDR_W];
            acc_wdata = bus.wdata_i;
            acc_wstrb = bus.wstrb_i;
            acc_oor   = in_oor;
          end else if (WAIT_CYCLES == 1) begin
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (bus.valid_i) overrun_d = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        // ACCESS is the final wait state, entered with cnt==1.
        if (cnt_q == CNT_W'(2)) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (bus.valid_i) overrun_d = 1'b1;
        fire    = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (fire) ready_d = 1'b1;
  end

  // Reset on the access edge abandons the request: no write, no read.
  assign ram_en  = fire && !acc_oor && !rst_i;
  assign ram_clr = fire && acc_oor && (acc_wstrb == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      oor_q     <= 1'b0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      oor_q     <= oor_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
    end
  end

  iob_ram_sp_be #(
    .DATA_W     (DATA_W),
    .MEM_ADDR_W (MEM_ADDR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (ram_en),
    .we_i    (acc_wstrb),
    .addr_i  (acc_idx),
    .wdata_i (acc_wdata),
    .clr_i   (ram_clr),
    .rdata_o (ram_rdata)
  );

  assign bus.rdata_o   = ram_rdata;
  assign bus.ready_o   = ready_q;
  assign bus.busy_o    = (state_q != ST_IDLE);
  assign bus.overrun_o = overrun_q;
endmodule

// File: tb/tb_iob_ram_wait_slave.sv
// Scoreboard bench: one DUT with two wait states, one with none.
module tb_iob_ram_wait_slave;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2, rst0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  iob_ram_wait_slave_if #(.ADDR_W(32), .DATA_W(32)) b2 ();
  iob_ram_wait_slave_if #(.ADDR_W(32), .DATA_W(32)) b0 ();

  iob_ram_wait_slave #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .WAIT_CYCLES(2))
    dut2 (.clk_i(clk), .rst_i(rst2), .bus(b2));
  iob_ram_wait_slave #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .WAIT_CYCLES(0))
    dut0 (.clk_i(clk), .rst_i(rst0), .bus(b0));

  typedef struct {
    int          due;
    logic [31:0] rdata;
  } exp_t;

  exp_t q2[$];
  exp_t q0[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic drive(input int w, input logic v, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    if (w == 2) begin
      b2.valid_i = v; b2.address_i = a; b2.wdata_i = d; b2.wstrb_i = s;
    end else begin
      b0.valid_i = v; b0.address_i = a; b0.wdata_i = d; b0.wstrb_i = s;
    end
  endtask

  // Expected response for a request accepted in the current cycle.
  task automatic push(input int w, input logic [31:0] r);
    exp_t e;
    e.rdata = r;
    if (w == 2) begin e.due = cyc + 3; q2.push_back(e); end
    else        begin e.due = cyc + 1; q0.push_back(e); end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic req_pulse(input int w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [31:0] r);
    step();
    drive(w, 1'b1, a, d, s);
    push(w, r);
    step();
    drive(w, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic drain(input int w);
    for (int i = 0; i < 30; i++) begin
      if ((w == 2 ? q2.size() : q0.size()) == 0) break;
      step();
    end
    if ((w == 2 ? q2.size() : q0.size()) != 0) begin
      total++; bad++;
      $display("FAIL w%0d_drain got=%0d pending exp=0", w, (w == 2 ? q2.size() : q0.size()));
      if (w == 2) q2.delete(); else q0.delete();
    end
    step();
  endtask

  // Monitors: every ready_o pulse must match the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (b2.ready_o === 1'b1) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL w2_unexpected_ready got=1 exp=0 (cycle %0d)", cyc);
      end else begin
        e = q2.pop_front();
        check("w2_ready_cycle", 32'(cyc), 32'(e.due));
        check("w2_rdata", b2.rdata_o, e.rdata);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b0.ready_o === 1'b1) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL w0_unexpected_ready got=1 exp=0 (cycle %0d)", cyc);
      end else begin
        e = q0.pop_front();
        check("w0_ready_cycle", 32'(cyc), 32'(e.due));
        check("w0_rdata", b0.rdata_o, e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with valid_i asserted: nothing may be accepted.
    rst2 = 1'b1; rst0 = 1'b1;
    drive(2, 1'b1, 32'h10, 32'h0, 4'h0);
    drive(0, 1'b1, 32'h10, 32'h0, 4'h0);
    repeat (3) step();
    check("rst_rdata",   b2.rdata_o,   32'h0);
    check("rst_ready",   32'(b2.ready_o),   32'h0);
    check("rst_busy",    32'(b2.busy_o),    32'h0);
    check("rst_overrun", 32'(b2.overrun_o), 32'h0);
    check("rst0_busy",   32'(b0.busy_o),    32'h0);
    drive(2, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst2 = 1'b0; rst0 = 1'b0;
    repeat (4) step();

    // Full write, with busy observed through the wait window.
    req_pulse(2, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0);
    check("busy_t1", 32'(b2.busy_o), 32'h1);
    step();
    check("busy_t2", 32'(b2.busy_o), 32'h1);
    step();
    check("busy_t3", 32'(b2.busy_o), 32'h0);
    drain(2);
    req_pulse(2, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF);
    drain(2);

    // Byte strobes; writes leave rdata_o at the previous read value.
    req_pulse(2, 32'h10, 32'h000000A5, 4'h1, 32'hDEADBEEF);
    drain(2);
    req_pulse(2, 32'h10, 32'h0, 4'h0, 32'hDEADBEA5);
    drain(2);
    req_pulse(2, 32'h10, 32'h12340000, 4'hC, 32'hDEADBEA5);
    drain(2);
    req_pulse(2, 32'h10, 32'h0, 4'h0, 32'h1234BEA5);
    drain(2);

    // Out of range: 0x1000 aliases word 0 in its low bits but must not touch it.
    req_pulse(2, 32'h0, 32'h11223344, 4'hF, 32'h1234BEA5);
    drain(2);
    req_pulse(2, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h1234BEA5);
    drain(2);
    req_pulse(2, 32'h0, 32'h0, 4'h0, 32'h11223344);
    drain(2);
    req_pulse(2, 32'h1000, 32'h0, 4'h0, 32'h0);
    drain(2);

    // Overrun: second request one cycle later is dropped.
    step();
    drive(2, 1'b1, 32'h0, 32'h0, 4'h0);
    push(2, 32'h11223344);
    check("ovr_t0", 32'(b2.overrun_o), 32'h0);
    step();
    drive(2, 1'b1, 32'h10, 32'h0, 4'h0);
    check("ovr_t1", 32'(b2.overrun_o), 32'h0);
    step();
    drive(2, 1'b0, 32'h0, 32'h0, 4'h0);
    check("ovr_t2", 32'(b2.overrun_o), 32'h1);
    drain(2);
    repeat (3) step();
    check("ovr_sticky", 32'(b2.overrun_o), 32'h1);

    // Reset one cycle into a write: abandoned, no response, array intact.
    step();
    drive(2, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF);
    step();
    drive(2, 1'b0, 32'h0, 32'h0, 4'h0);
    rst2 = 1'b1;
    repeat (2) step();
    rst2 = 1'b0;
    repeat (4) step();
    check("midrst_rdata",   b2.rdata_o, 32'h0);
    check("midrst_overrun", 32'(b2.overrun_o), 32'h0);
    check("midrst_busy",    32'(b2.busy_o), 32'h0);
    req_pulse(2, 32'h0, 32'h0, 4'h0, 32'h11223344);
    drain(2);

    // Zero wait states: single write, then a continuous back-to-back burst.
    req_pulse(0, 32'h20, 32'h55AA55AA, 4'hF, 32'h0);
    drain(0);
    step();
    drive(0, 1'b1, 32'h24, 32'h01020304, 4'hF);
    push(0, 32'h0);
    step();
    drive(0, 1'b1, 32'h20, 32'h0, 4'h0);
    push(0, 32'h55AA55AA);
    check("w0_busy", 32'(b0.busy_o), 32'h0);
    step();
    drive(0, 1'b1, 32'h24, 32'h0, 4'h0);
    push(0, 32'h01020304);
    step();
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    drain(0);
    check("w0_overrun", 32'(b0.overrun_o), 32'h0);

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
